// File: rtl/skeleton_pkg.sv
// Shared types and helpers for the skeleton writeback sequencer and the mask stage.
package skeleton_pkg;
    localparam int N_DEF    = 8;
    localparam int BIT_SIZE = 6;
    localparam int ADDR_W   = BIT_SIZE + 1;
    localparam int PIX_W    = 8;
    localparam int ITER_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_WAIT,
        ST_CAPTURE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    // True when a raster address lies on the outer ring of an N_DEF x N_DEF frame.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        int unsigned a;
        int unsigned row;
        int unsigned col;
        a   = int'(addr);
        row = a / N_DEF;
        col = a % N_DEF;
        return (row == 0) || (row == N_DEF - 1) || (col == 0) || (col == N_DEF - 1);
    endfunction
endpackage

// File: rtl/skeleton_writeback_if.sv
// Bundle of the source, mask-stage and result ports of the skeleton writeback sequencer.
interface skeleton_writeback_if
    import skeleton_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int PW = PIX_W
);
    logic              start;
    logic              img_valid;
    logic [PW-1:0]     img_data;
    logic              img_ready;
    logic              mask_we;
    logic [PW-1:0]     mask_data;
    logic              mask_wr_en;
    logic [AW-1:0]     mask_addr;
    logic [PW-1:0]     mask_pixel;
    logic [AW-1:0]     rd_addr;
    logic [PW-1:0]     rd_data;
    logic              busy;
    logic              done;
    logic              converged;
    logic              err;
    logic [ITER_W-1:0] iter_count;
    logic [AW-1:0]     change_count;

    modport master (
        output start, img_valid, img_data, mask_wr_en, mask_addr, mask_pixel, rd_addr,
        input  img_ready, mask_we, mask_data, rd_data, busy, done, converged, err,
               iter_count, change_count
    );

    modport slave (
        input  start, img_valid, img_data, mask_wr_en, mask_addr, mask_pixel, rd_addr,
        output img_ready, mask_we, mask_data, rd_data, busy, done, converged, err,
               iter_count, change_count
    );
endinterface

// File: rtl/skeleton_writeback_frame_ram.sv
// Working frame buffer: one synchronous write port and two asynchronous read ports.
module frame_ram #(
    parameter int DEPTH = 64,
    parameter int IW    = 6,
    parameter int PW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [IW-1:0] raddr_a,
    output logic [PW-1:0] rdata_a,
    input  logic [IW-1:0] raddr_b,
    output logic [PW-1:0] rdata_b
);
    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/skeleton_writeback.sv
// Frame-level sequencer around the mask stage: load, stream, capture and iterate
// until a pass makes no changes or the pass cap is reached.
module skeleton_writeback
    import skeleton_pkg::*;
#(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int MAX_ITER   = 15,
    parameter int WAIT_LIMIT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    skeleton_writeback_if.slave bus
);
    localparam int AW      = bitSize + 1;
    localparam int FRAME_N = N * N;
    localparam int IW      = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;
    localparam int WW      = $clog2(WAIT_LIMIT + 1);
    localparam int WL1     = WAIT_LIMIT - 1;

    localparam logic [AW:0]        FRAME     = FRAME_N[AW:0];
    localparam logic [AW:0]        LAST_IDX  = FRAME - 1'b1;
    localparam logic [WW-1:0]      WAIT_LAST = WL1[WW-1:0];
    localparam logic [ITER_W-1:0]  ITER_CAP  = MAX_ITER[ITER_W-1:0];

    state_t                  state;
    state_t                  state_next;
    logic [AW:0]             idx;
    logic                    phase;
    logic [WW-1:0]           wait_cnt;
    logic [ITER_W-1:0]       iter_q;
    logic [AW-1:0]           change_q;
    logic [AW-1:0]           last_addr;
    logic                    last_valid;
    logic                    converged_q;
    logic                    err_q;

    logic                    ram_we;
    logic [IW-1:0]           ram_waddr;
    logic [IW-1:0]           ram_raddr_a;
    logic [pixelWidth-1:0]   ram_wdata;
    logic [pixelWidth-1:0]   ram_rdata_a;
    logic [pixelWidth-1:0]   ram_rdata_b;

    logic                    img_ready_c;
    logic                    mask_we_c;
    logic                    capturing;
    logic                    in_range;
    logic                    rd_in_range;
    logic                    sampling;
    logic                    is_new;
    logic                    changed;
    logic [AW-1:0]           base_count;
    logic [AW-1:0]           count_next;

    frame_ram #(
        .DEPTH (FRAME_N),
        .IW    (IW),
        .PW    (pixelWidth)
    ) u_frame_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (ram_raddr_a),
        .rdata_a (ram_rdata_a),
        .raddr_b (bus.rd_addr[IW-1:0]),
        .rdata_b (ram_rdata_b)
    );

    assign capturing   = (state == ST_WAIT) || (state == ST_CAPTURE);
    assign in_range    = {1'b0, bus.mask_addr} < FRAME;
    assign rd_in_range = {1'b0, bus.rd_addr} < FRAME;
    assign sampling    = capturing && bus.mask_wr_en && in_range;

    // A sample taken in WAIT opens a new pass, so last pass's count and address history are ignored.
    assign base_count  = (state == ST_CAPTURE) ? change_q : '0;
    assign is_new      = !((state == ST_CAPTURE) && last_valid) || (bus.mask_addr != last_addr);
    assign changed     = sampling && is_new && (ram_rdata_a != bus.mask_pixel);
    assign count_next  = (changed && (base_count != '1)) ? base_count + 1'b1 : base_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        img_ready_c = 1'b0;
        mask_we_c   = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = idx[IW-1:0];
        ram_wdata   = bus.img_data;
        ram_raddr_a = idx[IW-1:0];
        case (state)
            ST_IDLE: begin
                if (bus.start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                img_ready_c = 1'b1;
                ram_we      = bus.img_valid;
                if (bus.img_valid && (idx == LAST_IDX)) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                mask_we_c = 1'b1;
                if (phase && (idx == LAST_IDX)) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                ram_raddr_a = bus.mask_addr[IW-1:0];
                ram_waddr   = bus.mask_addr[IW-1:0];
                ram_wdata   = bus.mask_pixel;
                ram_we      = bus.mask_wr_en && in_range;
                if (bus.mask_wr_en) begin
                    state_next = ST_CAPTURE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                ram_raddr_a = bus.mask_addr[IW-1:0];
                ram_waddr   = bus.mask_addr[IW-1:0];
                ram_wdata   = bus.mask_pixel;
                ram_we      = bus.mask_wr_en && in_range;
                if (!bus.mask_wr_en) state_next = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (change_q == '0) begin
                    state_next = ST_DONE;
                end else if ((iter_q + 8'd1) == ITER_CAP) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_STREAM;
                end
            end
            ST_DONE: begin
                if (bus.start) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            phase       <= 1'b0;
            wait_cnt    <= '0;
            iter_q      <= '0;
            change_q    <= '0;
            last_addr   <= '0;
            last_valid  <= 1'b0;
            converged_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        idx         <= '0;
                        phase       <= 1'b0;
                        iter_q      <= '0;
                        change_q    <= '0;
                        converged_q <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.img_valid) begin
                        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        phase <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    phase    <= ~phase;
                    wait_cnt <= '0;
                    if (phase) begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    change_q   <= count_next;
                    last_valid <= 1'b0;
                    wait_cnt   <= wait_cnt + 1'b1;
                    if (sampling) begin
                        last_addr  <= bus.mask_addr;
                        last_valid <= 1'b1;
                    end
                    if (!bus.mask_wr_en && (wait_cnt == WAIT_LAST)) begin
                        err_q <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (sampling) begin
                        change_q   <= count_next;
                        last_addr  <= bus.mask_addr;
                        last_valid <= 1'b1;
                    end
                end
                ST_DECIDE: begin
                    iter_q <= iter_q + 8'd1;
                    idx    <= '0;
                    phase  <= 1'b0;
                    if (change_q == '0) begin
                        converged_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.img_ready    = img_ready_c;
    assign bus.mask_we      = mask_we_c;
    assign bus.mask_data    = mask_we_c ? ram_rdata_a : '0;
    assign bus.rd_data      = rd_in_range ? ram_rdata_b : '0;
    assign bus.busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign bus.done         = (state == ST_DONE);
    assign bus.converged    = converged_q;
    assign bus.err          = err_q;
    assign bus.iter_count   = iter_q;
    assign bus.change_count = change_q;
endmodule

// File: tb/tb_skeleton_writeback.sv
// Directed bench for skeleton_writeback: a behavioural mask stage plays back thinned frames.
module tb_skeleton_writeback;
    import skeleton_pkg::*;

    localparam int NPIX        = 64;
    localparam int MODE_IDENT  = 0;
    localparam int MODE_THIN   = 1;
    localparam int MODE_FLIP9  = 2;
    localparam int MODE_REPEAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       start;
    logic       img_valid;
    logic [7:0] img_data;
    logic       mask_wr_en;
    logic [6:0] mask_addr;
    logic [7:0] mask_pixel;
    logic [6:0] rd_addr;

    logic       img_ready;
    logic       mask_we;
    logic [7:0] mask_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       converged;
    logic       err;
    logic [7:0] iter_count;
    logic [6:0] change_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] img    [NPIX];
    logic [7:0] model  [NPIX];
    logic [7:0] pix    [NPIX];
    logic [7:0] outPix [NPIX];

    skeleton_writeback_if bus_a ();
    skeleton_writeback_if bus_b ();

    skeleton_writeback #(.MAX_ITER(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    skeleton_writeback #(.MAX_ITER(3)) dut_cap3 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    assign bus_a.start      = start & ~sel;
    assign bus_b.start      = start & sel;
    assign bus_a.img_valid  = img_valid;
    assign bus_b.img_valid  = img_valid;
    assign bus_a.img_data   = img_data;
    assign bus_b.img_data   = img_data;
    assign bus_a.mask_wr_en = mask_wr_en;
    assign bus_b.mask_wr_en = mask_wr_en;
    assign bus_a.mask_addr  = mask_addr;
    assign bus_b.mask_addr  = mask_addr;
    assign bus_a.mask_pixel = mask_pixel;
    assign bus_b.mask_pixel = mask_pixel;
    assign bus_a.rd_addr    = rd_addr;
    assign bus_b.rd_addr    = rd_addr;

    assign img_ready    = sel ? bus_b.img_ready    : bus_a.img_ready;
    assign mask_we      = sel ? bus_b.mask_we      : bus_a.mask_we;
    assign mask_data    = sel ? bus_b.mask_data    : bus_a.mask_data;
    assign rd_data      = sel ? bus_b.rd_data      : bus_a.rd_data;
    assign busy         = sel ? bus_b.busy         : bus_a.busy;
    assign done         = sel ? bus_b.done         : bus_a.done;
    assign converged    = sel ? bus_b.converged    : bus_a.converged;
    assign err          = sel ? bus_b.err          : bus_a.err;
    assign iter_count   = sel ? bus_b.iter_count   : bus_a.iter_count;
    assign change_count = sel ? bus_b.change_count : bus_a.change_count;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic setImage(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            if (kind == 0) begin
                img[i] = 8'd0;
            end else if (kind == 1) begin
                img[i] = ((i / 8 >= 2) && (i / 8 <= 5) && (i % 8 >= 2) && (i % 8 <= 5)) ? 8'd255 : 8'd0;
            end else begin
                img[i] = 8'(i * 3);
            end
        end
    endtask

    task automatic loadImage();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("img_ready", 32'(img_ready), 1);
        checkOutput("start_clears_err", 32'(err), 0);
        for (int i = 0; i < NPIX; i++) begin
            if (i % 9 == 4) begin
                img_valid = 1'b0;
                @(negedge clk);
            end
            img_valid = 1'b1;
            img_data  = img[i];
            @(negedge clk);
            model[i] = img[i];
        end
        img_valid = 1'b0;
    endtask

    task automatic streamFrame();
        int guard;
        int bad;
        guard = 0;
        bad   = 0;
        while (!mask_we && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stream_start", 32'(mask_we), 1);
        for (int k = 0; k < 2 * NPIX; k++) begin
            if (!mask_we) begin
                bad++;
            end else if (k % 2 == 0) begin
                pix[k / 2] = mask_data;
                if (mask_data !== model[k / 2]) bad++;
            end else if (mask_data !== pix[k / 2]) begin
                bad++;
            end
            @(negedge clk);
        end
        checkOutput("stream_data", bad, 0);
        checkOutput("stream_end", 32'(mask_we), 0);
    endtask

    task automatic playBack(input int mode, input int passNo);
        int reps;
        int expChanges;
        reps       = (mode == MODE_REPEAT) ? 2 : 1;
        expChanges = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (mode == MODE_THIN) begin
                outPix[a] = (a / 8 == 3) ? model[a] : 8'd0;
            end else if (mode == MODE_FLIP9) begin
                outPix[a] = (a == 9) ? ~model[a] : model[a];
            end else if (mode == MODE_REPEAT) begin
                outPix[a] = ((a == 5) || (a == 40)) ? ~model[a] : model[a];
            end else begin
                outPix[a] = model[a];
            end
            if (outPix[a] !== model[a]) expChanges++;
        end
        repeat (3) @(negedge clk);
        for (int a = 0; a < NPIX; a++) begin
            for (int r = 0; r < reps; r++) begin
                mask_wr_en = 1'b1;
                mask_addr  = 7'(a);
                mask_pixel = outPix[a];
                @(negedge clk);
            end
            if ((mode == MODE_REPEAT) && (a == 6)) begin
                mask_addr  = 7'd70;
                mask_pixel = 8'hAA;
                @(negedge clk);
            end
            model[a] = outPix[a];
        end
        mask_wr_en = 1'b0;
        mask_addr  = 7'd0;
        mask_pixel = 8'd0;
        repeat (2) @(negedge clk);
        checkOutput("change_count", 32'(change_count), expChanges);
        checkOutput("iter_count", 32'(iter_count), passNo);
    endtask

    task automatic checkRead(input int addr, input int expected);
        rd_addr = 7'(addr);
        #1;
        checkOutput("rd_data", 32'(rd_data), expected);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int bad;
        rst        = 1'b1;
        sel        = 1'b0;
        start      = 1'b0;
        img_valid  = 1'b0;
        img_data   = 8'd0;
        mask_wr_en = 1'b0;
        mask_addr  = 7'd0;
        mask_pixel = 8'd0;
        rd_addr    = 7'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_img_ready", 32'(img_ready), 0);
        checkOutput("reset_mask_we", 32'(mask_we), 0);
        checkOutput("reset_iter", 32'(iter_count), 0);
        checkOutput("reset_err", 32'(err), 0);
        rst = 1'b0;

        $display("[TB] all-zero image");
        setImage(0);
        loadImage();
        streamFrame();
        playBack(MODE_IDENT, 1);
        checkOutput("zero_done", 32'(done), 1);
        checkOutput("zero_converged", 32'(converged), 1);
        checkRead(20, 0);

        $display("[TB] 4x4 block thinned to a line");
        setImage(1);
        loadImage();
        streamFrame();
        playBack(MODE_THIN, 1);
        streamFrame();
        playBack(MODE_THIN, 2);
        checkOutput("block_done", 32'(done), 1);
        checkOutput("block_converged", 32'(converged), 1);
        checkRead(26, 255);
        checkRead(29, 255);
        checkRead(18, 0);
        checkRead(45, 0);
        bad = 0;
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = 7'(a);
            #1;
            if (rd_data !== (((a / 8 == 3) && (a % 8 >= 2) && (a % 8 <= 5)) ? 8'd255 : 8'd0)) bad++;
        end
        checkOutput("block_skeleton", bad, 0);

        $display("[TB] repeated samples and out-of-range address");
        setImage(2);
        loadImage();
        streamFrame();
        playBack(MODE_REPEAT, 1);
        streamFrame();
        playBack(MODE_IDENT, 2);
        checkOutput("repeat_converged", 32'(converged), 1);
        checkRead(5, 240);
        checkRead(40, 135);
        checkRead(6, 18);

        $display("[TB] mask never answers");
        loadImage();
        streamFrame();
        k = 0;
        while (!done && k < 2000) begin
            k++;
            @(negedge clk);
        end
        checkOutput("wait_len", k, 1023);
        checkOutput("timeout_err", 32'(err), 1);
        checkOutput("timeout_busy", 32'(busy), 0);
        checkOutput("timeout_converged", 32'(converged), 0);
        checkOutput("timeout_iter", 32'(iter_count), 0);

        $display("[TB] reset during stream, then rerun");
        loadImage();
        k = 0;
        while (!mask_we && k < 50) begin
            k++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_mask_we", 32'(mask_we), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        rst = 1'b0;
        loadImage();
        streamFrame();
        playBack(MODE_IDENT, 1);
        checkOutput("rerun_done", 32'(done), 1);
        checkOutput("rerun_converged", 32'(converged), 1);
        checkRead(63, 189);

        $display("[TB] pixel 9 always flips, pass cap 3");
        sel = 1'b1;
        loadImage();
        streamFrame();
        playBack(MODE_FLIP9, 1);
        streamFrame();
        playBack(MODE_FLIP9, 2);
        streamFrame();
        playBack(MODE_FLIP9, 3);
        checkOutput("cap_done", 32'(done), 1);
        checkOutput("cap_converged", 32'(converged), 0);
        checkRead(9, 228);
        checkRead(10, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
